// File: rtl/irq_ctl_if.sv
// Core-side signal bundle for the 65C02 interrupt/halt controller.
// master = microcode sequencer + pins, slave = irq_ctl.
interface irq_ctl_if;
  logic       irq;
  logic       nmi;
  logic       I;
  logic       sync;
  logic       brk;
  logic       wai;
  logic       stp;
  logic       vec_ack;
  logic       take_irq;
  logic [1:0] vec_sel;
  logic       B;
  logic       halt;

  modport master (
    output irq, nmi, I, sync, brk, wai, stp, vec_ack,
    input  take_irq, vec_sel, B, halt
  );

  modport slave (
    input  irq, nmi, I, sync, brk, wai, stp, vec_ack,
    output take_irq, vec_sel, B, halt
  );
endinterface

// File: rtl/irq_ctl.sv
// Interrupt and halt controller: pin synchronizers, NMI edge latch, boundary
// decision for interrupt entry, vector/B selection and WAI/STP halt states.
module irq_ctl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  irq_ctl_if.slave    bus
);

  localparam int unsigned VW = 2;
  localparam logic [VW-1:0] VEC_NONE = 2'b00;
  localparam logic [VW-1:0] VEC_NMI  = 2'b01;
  localparam logic [VW-1:0] VEC_RST  = 2'b10;
  localparam logic [VW-1:0] VEC_IRQ  = 2'b11;

  typedef enum logic [2:0] {
    ST_RST,
    ST_RUN,
    ST_SERV,
    ST_WAIT,
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic                 nmi_prev_q;
  logic                 nmi_pend_q, nmi_pend_d;
  logic [VW-1:0]        vec_sel_q, vec_sel_d;
  logic                 b_q, b_d;
  logic                 halt_q, halt_d;
  logic                 take_irq_c;

  logic irq_s;
  logic nmi_s;
  logic nmi_rise;
  logic irq_req;

  // Shift chains: stage 0 takes the pin, last stage is the synchronized level.
  always_comb begin
    irq_sync_d    = irq_sync_q;
    nmi_sync_d    = nmi_sync_q;
    irq_sync_d[0] = bus.irq;
    nmi_sync_d[0] = bus.nmi;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      irq_sync_d[i] = irq_sync_q[i-1];
      nmi_sync_d[i] = nmi_sync_q[i-1];
    end
  end

  assign irq_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign nmi_rise = nmi_s & ~nmi_prev_q;
  assign irq_req  = irq_s & ~bus.I;

  // A new edge in the same cycle as the acknowledge re-arms the request.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (bus.vec_ack && (vec_sel_q == VEC_NMI)) nmi_pend_d = 1'b0;
    if (nmi_rise && (state_q != ST_STOP))      nmi_pend_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    vec_sel_d  = vec_sel_q;
    b_d        = b_q;
    halt_d     = halt_q;
    take_irq_c = 1'b0;

    unique case (state_q)
      ST_RST: begin
        if (bus.vec_ack) begin
          vec_sel_d = VEC_NONE;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        take_irq_c = bus.sync & (nmi_pend_q | irq_req);
        if (take_irq_c) begin
          vec_sel_d = nmi_pend_q ? VEC_NMI : VEC_IRQ;
          b_d       = 1'b0;
          state_d   = ST_SERV;
        end else if (bus.brk) begin
          vec_sel_d = VEC_IRQ;
          b_d       = 1'b1;
          state_d   = ST_SERV;
        end else if (bus.stp) begin
          halt_d  = 1'b1;
          state_d = ST_STOP;
        end else if (bus.wai) begin
          halt_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_SERV: begin
        if (bus.vec_ack) begin
          vec_sel_d = VEC_NONE;
          b_d       = 1'b0;
          state_d   = ST_RUN;
        end
      end
      // Wake ignores I; the mask is applied by the normal entry rule in RUN.
      ST_WAIT: begin
        if (irq_s || nmi_pend_q) begin
          halt_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST;
      irq_sync_q <= '0;
      nmi_sync_q <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      vec_sel_q  <= VEC_RST;
      b_q        <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_sync_q <= irq_sync_d;
      nmi_sync_q <= nmi_sync_d;
      nmi_prev_q <= nmi_s;
      nmi_pend_q <= nmi_pend_d;
      vec_sel_q  <= vec_sel_d;
      b_q        <= b_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.take_irq = take_irq_c;
  assign bus.vec_sel  = vec_sel_q;
  assign bus.B        = b_q;
  assign bus.halt     = halt_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a pin-history reference model.
module tb_irq_ctl;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int M_RST  = 0;
  localparam int M_RUN  = 1;
  localparam int M_SERV = 2;
  localparam int M_WAIT = 3;
  localparam int M_STOP = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_ctl_if bus ();

  irq_ctl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int stop_cnt = 0;

  // Reference model state; pin histories hold past samples, index 0 newest.
  int         m_state;
  logic [1:0] m_vec;
  logic       m_b;
  logic       m_halt;
  logic       m_pend;
  logic       irq_hist[$];
  logic       nmi_hist[$];

  logic irq_lvl = 1'b0;
  logic nmi_lvl = 1'b0;
  logic i_lvl   = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = M_RST;
    m_vec   = 2'b10;
    m_b     = 1'b0;
    m_halt  = 1'b0;
    m_pend  = 1'b0;
    irq_hist.delete();
    nmi_hist.delete();
    for (int i = 0; i <= int'(SYNC_STAGES); i++) begin
      irq_hist.push_back(1'b0);
      nmi_hist.push_back(1'b0);
    end
  endtask

  function automatic logic m_take(input logic sync_v);
    logic irq_seen;
    irq_seen = irq_hist[SYNC_STAGES-1];
    return (m_state == M_RUN) && sync_v && (m_pend || (irq_seen && !i_lvl));
  endfunction

  task automatic model_step(input logic sync_v, input logic brk_v, input logic wai_v,
                            input logic stp_v, input logic ack_v);
    logic irq_seen, nmi_seen, nmi_before, take, nmi_rise, pend_n;
    irq_seen   = irq_hist[SYNC_STAGES-1];
    nmi_seen   = nmi_hist[SYNC_STAGES-1];
    nmi_before = nmi_hist[SYNC_STAGES];
    take       = m_take(sync_v);
    nmi_rise   = nmi_seen && !nmi_before;
    pend_n     = m_pend;
    if (ack_v && m_vec == 2'b01) pend_n = 1'b0;
    if (nmi_rise && m_state != M_STOP) pend_n = 1'b1;
    case (m_state)
      M_RST:  if (ack_v) begin m_vec = 2'b00; m_state = M_RUN; end
      M_RUN: begin
        if (take) begin
          m_vec = m_pend ? 2'b01 : 2'b11; m_b = 1'b0; m_state = M_SERV;
        end else if (brk_v) begin
          m_vec = 2'b11; m_b = 1'b1; m_state = M_SERV;
        end else if (stp_v) begin
          m_halt = 1'b1; m_state = M_STOP;
        end else if (wai_v) begin
          m_halt = 1'b1; m_state = M_WAIT;
        end
      end
      M_SERV: if (ack_v) begin m_vec = 2'b00; m_b = 1'b0; m_state = M_RUN; end
      M_WAIT: if (irq_seen || m_pend) begin m_halt = 1'b0; m_state = M_RUN; end
      default: ;
    endcase
    m_pend = pend_n;
    irq_hist.push_front(irq_lvl);
    nmi_hist.push_front(nmi_lvl);
    void'(irq_hist.pop_back());
    void'(nmi_hist.pop_back());
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic sync_v, input logic brk_v, input logic wai_v,
                       input logic stp_v, input logic ack_v);
    bus.irq = irq_lvl; bus.nmi = nmi_lvl; bus.I = i_lvl;
    bus.sync = sync_v; bus.brk = brk_v; bus.wai = wai_v; bus.stp = stp_v; bus.vec_ack = ack_v;
    #1;
    check("take_irq", 8'(bus.take_irq), 8'(m_take(sync_v)));
    check("vec_sel",  8'(bus.vec_sel),  8'(m_vec));
    check("B",        8'(bus.B),        8'(m_b));
    check("halt",     8'(bus.halt),     8'(m_halt));
    @(posedge clk);
    model_step(sync_v, brk_v, wai_v, stp_v, ack_v);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.sync = 1'b1; bus.brk = 1'b0; bus.wai = 1'b0; bus.stp = 1'b0; bus.vec_ack = 1'b0;
    #1;
    model_reset();
    check("rst_vec_sel",  8'(bus.vec_sel),  8'h02);
    check("rst_halt",     8'(bus.halt),     8'h00);
    check("rst_B",        8'(bus.B),        8'h00);
    check("rst_take_irq", 8'(bus.take_irq), 8'h00);
    repeat (n) @(negedge clk);
    reset    = 1'b0;
    bus.sync = 1'b0;
  endtask

  initial begin
    bus.irq = 1'b0; bus.nmi = 1'b0; bus.I = 1'b0; bus.sync = 1'b0;
    bus.brk = 1'b0; bus.wai = 1'b0; bus.stp = 1'b0; bus.vec_ack = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Reset in SERV with an NMI pending, then confirm the pending bit is gone.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_run_vec", 8'(bus.vec_sel), 8'h00);
    nmi_lvl = 1'b1; idle(SYNC_STAGES + 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_serv_vec", 8'(bus.vec_sel), 8'h01);
    nmi_lvl = 1'b0; idle(SYNC_STAGES + 1);
    nmi_lvl = 1'b1; idle(SYNC_STAGES + 2);
    nmi_lvl = 1'b0;
    do_reset(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // IRQ masking; the take cycle also carries a brk that must be ignored.
    irq_lvl = 1'b1; i_lvl = 1'b1;
    for (int k = 0; k < 6; k++) cycle(1'(k % 2), 1'b0, 1'b0, 1'b0, 1'b0);
    i_lvl = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_vec", 8'(bus.vec_sel), 8'h03);
    check("t2_B",   8'(bus.B),       8'h00);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_lvl = 1'b0; idle(SYNC_STAGES + 1);

    // NMI beats IRQ; a held NMI is not retaken; a new edge is.
    irq_lvl = 1'b1; nmi_lvl = 1'b1; idle(SYNC_STAGES + 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_nmi_vec", 8'(bus.vec_sel), 8'h01);
    idle(2); cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_irq_vec", 8'(bus.vec_sel), 8'h03);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_lvl = 1'b0; idle(SYNC_STAGES + 1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nmi_lvl = 1'b0; idle(SYNC_STAGES + 1);
    nmi_lvl = 1'b1; idle(SYNC_STAGES + 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_renmi_vec", 8'(bus.vec_sel), 8'h01);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // BRK, with an NMI edge arriving during service.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_brk_vec", 8'(bus.vec_sel), 8'h03);
    check("t4_brk_B",   8'(bus.B),       8'h01);
    nmi_lvl = 1'b0; idle(SYNC_STAGES + 1);
    nmi_lvl = 1'b1; idle(SYNC_STAGES + 2);
    check("t4_frozen_vec", 8'(bus.vec_sel), 8'h03);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_nmi_vec", 8'(bus.vec_sel), 8'h01);
    check("t4_nmi_B",   8'(bus.B),       8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nmi_lvl = 1'b0; idle(SYNC_STAGES + 1);

    // WAI: masked wake resumes without a take, unmasked wake takes at next sync.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_halt", 8'(bus.halt), 8'h01);
    i_lvl = 1'b1; irq_lvl = 1'b1; idle(SYNC_STAGES + 2);
    check("t5_wake", 8'(bus.halt), 8'h00);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    irq_lvl = 1'b0; idle(SYNC_STAGES + 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    i_lvl = 1'b0; irq_lvl = 1'b1; idle(SYNC_STAGES + 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_take_vec", 8'(bus.vec_sel), 8'h03);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_lvl = 1'b0; idle(SYNC_STAGES + 1);

    // STP with WAI together, then 50 cycles of ignored activity.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_halt", 8'(bus.halt), 8'h01);
    for (int k = 0; k < 50; k++) begin
      if (k % 4 == 0) nmi_lvl = ~nmi_lvl;
      irq_lvl = 1'($urandom_range(0, 1));
      i_lvl   = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("t6_still_halt", 8'(bus.halt), 8'h01);
    nmi_lvl = 1'b0; irq_lvl = 1'b0; i_lvl = 1'b0;
    do_reset(2);

    // Randomized traffic within the sequencer protocol.
    for (int k = 0; k < 3000; k++) begin
      logic s, b, w, p, a;
      int   r;
      if ($urandom_range(0, 15) == 0) irq_lvl = ~irq_lvl;
      if ($urandom_range(0, 11) == 0) nmi_lvl = ~nmi_lvl;
      if ($urandom_range(0, 19) == 0) i_lvl   = ~i_lvl;
      s = ($urandom_range(0, 3) == 0);
      b = 1'b0; w = 1'b0; p = 1'b0; a = 1'b0;
      r = int'($urandom_range(0, 59));
      if (m_state == M_RUN && !s) begin
        b = (r == 0);
        w = (r == 1);
        p = (r == 2) && ($urandom_range(0, 3) == 0);
      end
      if ((m_state == M_SERV || m_state == M_RST) && $urandom_range(0, 2) == 0) a = 1'b1;
      if (m_state == M_STOP) stop_cnt++;
      if (stop_cnt > 30 || $urandom_range(0, 999) == 0) begin
        stop_cnt = 0;
        do_reset(1);
      end else begin
        cycle(s, b, w, p, a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
Interrupt and halt controller for the microcoded 65C02 core. It synchronizes the external irq/nmi pins, detects NMI edges and holds pending requests. At each instruction boundary it decides whether the sequencer diverts to the interrupt microcode, and it selects the vector (NMI/RESET/IRQ-BRK) plus the B bit to push. It also implements the WAI and STP halt states and drives a stall to the core.

Parameters:
SYNC_STAGES, 2, flip-flop stages on irq and nmi pins (legal 1..3)

Ports:
clk       input   1  core clock
reset     input   1  asynchronous, active-high reset
irq       input   1  level interrupt request, active-high
nmi       input   1  non-maskable request, active-high, rising-edge sensitive
I         input   1  processor I flag
sync      input   1  sequencer at instruction boundary (opcode decode cycle)
brk       input   1  one-cycle pulse from microcode: BRK entering vector sequence
wai       input   1  one-cycle pulse: WAI executed
stp       input   1  one-cycle pulse: STP executed
vec_ack   input   1  one-cycle pulse: vector low byte fetched
take_irq  output  1  divert sequencer to interrupt microcode (combinational)
vec_sel   output  2  01=NMI $FFFA, 10=RESET $FFFC, 11=IRQ/BRK $FFFE, 00=none
B         output  1  B bit for status push (1=BRK, 0=hardware)
halt      output  1  stall core (WAI/STP)

Behaviour:
- Reset (async, any state, any cycle): state=RST. Synchronizer flops=0, nmi_prev=0, nmi_pend=0. Outputs: vec_sel=10, B=0, halt=0, take_irq=0.
- Synchronizers: irq_s and nmi_s lag their pins by exactly SYNC_STAGES clocks.
- NMI edge: nmi_s=1 with nmi_prev=0 sets nmi_pend, except in STOP. nmi_pend clears on vec_ack when vec_sel=01. An edge arriving in the same cycle as that clear sets the bit again; set wins.
- irq_req = irq_s & ~I. Level-sensitive, never latched.
- States: RST, RUN, SERV, WAIT, STOP.
- RST: take_irq=0. On vec_ack: vec_sel->00, state->RUN.
- RUN: take_irq = sync & (nmi_pend | irq_req). When take_irq=1: vec_sel<=(nmi_pend ? 01 : 11), B<=0, state->SERV.
- RUN, brk=1 and take_irq=0: vec_sel<=11, B<=1, state->SERV. brk in the same cycle as take_irq is ignored.
- RUN, wai=1: state->WAIT, halt<=1. stp=1: state->STOP, halt<=1. stp beats wai.
- SERV: take_irq=0. vec_sel and B are frozen; there is no hijack. On vec_ack: vec_sel->00, B->0, state->RUN. brk/wai/stp are ignored.
- WAIT: take_irq=0, halt=1.
  - Wake condition: irq_s=1 (regardless of I) or nmi_pend=1. On wake: halt<=0 and state->RUN in the next cycle.
  - Interrupt entry then happens at the following sync through the normal RUN rule. With I=1 and no NMI, execution resumes without a take.
- STOP: halt=1, take_irq=0. All inputs are ignored. Only reset exits.
- Registered outputs (vec_sel, B, halt) change one clock after the causing event. take_irq is valid in the same cycle as sync.
- Protocol errors are don't-care: vec_ack in RUN, or wai/stp outside RUN.

Test Plan:
1. Reset: assert reset mid-SERV with nmi_pend=1 -> immediately vec_sel=10, halt=0, take_irq=0, nmi_pend=0. Release, pulse vec_ack -> vec_sel=00, state RUN.
2. IRQ masking: irq=1, I=1, sync pulses -> take_irq stays 0. Drop I to 0 -> take_irq=1 on the first sync, which occurs SYNC_STAGES cycles or more after irq rises. Then vec_sel=11, B=0, take_irq=0 until vec_ack.
3. NMI priority/edge: irq=1, I=0, and an nmi rising edge both resolved before sync -> vec_sel=01. After vec_ack, hold nmi=1 -> no second NMI; the IRQ is taken next with vec_sel=11. Toggle nmi 0->1 -> new NMI.
4. BRK: brk pulse in RUN with sync=0 -> vec_sel=11, B=1. An NMI edge during SERV does not change vec_sel. After vec_ack, the NMI is taken at the next sync with vec_sel=01, B=0.
5. WAI: wai pulse -> halt=1. Raise irq with I=1 -> halt=0 one cycle after irq_s=1, no take_irq. Repeat with I=0 -> take_irq at the first sync after resume.
6. STP: stp and wai pulsed together -> STOP, halt=1. nmi edges and irq are ignored over 50 cycles. Reset -> halt=0, vec_sel=10.
